// File: rtl/ex_div_ctrl_if.sv
// Divide request/response bundle between the EX stage and the divide sequencer.
// The EX stage uses the master modport and the sequencer uses the slave modport.
interface ex_div_ctrl_if;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [63:0] div_result;
  logic        div_ready;

  modport master (
    output div_start, div_signed, div_annul, div_op1, div_op2,
    input  div_result, div_ready
  );

  modport slave (
    input  div_start, div_signed, div_annul, div_op1, div_op2,
    output div_result, div_ready
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divide sequencer (32 quotient bits, one per cycle) plus the
// pipeline stall vector generator for the EX stage.
module ex_div_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stallreq_id,
  output logic [5:0] stall,
  ex_div_ctrl_if.slave div
);

  typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  logic [32:0] shifted;
  logic [31:0] diff_lo;
  logic        diff_ge;
  logic        stallreq_ex;

  // Partial remainder shifted left with the next dividend bit; the 33-bit compare
  // decides the quotient bit, and only the low 32 bits of the difference survive.
  assign shifted = {rem_q, quo_q[31]};
  assign diff_ge = (shifted >= {1'b0, dvsr_q});
  assign diff_lo = shifted[31:0] - dvsr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (div.div_start && !div.div_annul) begin
          if (div.div_op2 == 32'd0) begin
            state_d = StDivZero;
          end else begin
            state_d   = StOn;
            cnt_d     = 6'd0;
            rem_d     = 32'd0;
            quo_d     = (div.div_signed && div.div_op1[31]) ? -div.div_op1 : div.div_op1;
            dvsr_d    = (div.div_signed && div.div_op2[31]) ? -div.div_op2 : div.div_op2;
            neg_quo_d = div.div_signed && (div.div_op1[31] ^ div.div_op2[31]);
            neg_rem_d = div.div_signed && div.div_op1[31];
          end
        end
      end
      StDivZero: begin
        if (div.div_annul) begin
          state_d = StIdle;
        end else begin
          result_d = 64'd0;
          state_d  = StEnd;
        end
      end
      StOn: begin
        if (div.div_annul) begin
          state_d = StIdle;
        end else if (cnt_q != 6'd32) begin
          rem_d = diff_ge ? diff_lo : shifted[31:0];
          quo_d = {quo_q[30:0], diff_ge};
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {(neg_rem_q ? -rem_q : rem_q), (neg_quo_q ? -quo_q : quo_q)};
          state_d  = StEnd;
        end
      end
      StEnd: begin
        if (!div.div_start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign div.div_ready  = (state_q == StEnd);
  assign div.div_result = result_q;

  assign stallreq_ex = div.div_start && !div.div_ready && !div.div_annul;

  // Stall is forced off while reset is held, even if EX is still requesting.
  always_comb begin
    stall = 6'b000000;
    if (reset_n) begin
      if (stallreq_ex)      stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: expected results queued at request time and
// compared when div_ready rises, with stall, latency, annul and reset checks.
module tb_ex_div_ctrl;

  logic       clk;
  logic       reset_n;
  logic       stallreq_id;
  logic [5:0] stall;

  ex_div_ctrl_if dif ();

  ex_div_ctrl u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stallreq_id (stallreq_id),
    .stall       (stall),
    .div         (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic id_req);
    int          cycles;
    int          bad_stall;
    int          lat;
    logic [63:0] exp;
    lat = (b == 32'd0) ? 2 : 34;
    @(posedge clk); #1;
    dif.div_start  = 1'b1;
    dif.div_signed = sgn;
    dif.div_op1    = a;
    dif.div_op2    = b;
    stallreq_id    = id_req;
    sb_q.push_back(model(a, b, sgn));
    cycles    = 0;
    bad_stall = 0;
    while (cycles < 60) begin
      @(negedge clk);
      if (dif.div_ready) break;
      if (stall !== 6'b001111) bad_stall++;
      cycles++;
    end
    check("latency", 64'(cycles), 64'(lat));
    check("stall_busy_bad_cycles", 64'(bad_stall), 64'd0);
    check("ready_high", {63'd0, dif.div_ready}, 64'd1);
    check("stall_at_ready", {58'd0, stall}, {58'd0, (id_req ? 6'b000111 : 6'b000000)});
    exp = sb_q.pop_front();
    check("result", dif.div_result, exp);
    @(posedge clk); #1;
    dif.div_start = 1'b0;
    stallreq_id   = 1'b0;
    @(negedge clk);
    check("ready_held_until_edge", {63'd0, dif.div_ready}, 64'd1);
    @(negedge clk);
    check("ready_dropped", {63'd0, dif.div_ready}, 64'd0);
    check("result_held", dif.div_result, exp);
  endtask

  logic [63:0] prev_result;
  int          ready_seen;

  initial begin
    reset_n        = 1'b0;
    stallreq_id    = 1'b0;
    dif.div_start  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_annul  = 1'b0;
    dif.div_op1    = 32'd0;
    dif.div_op2    = 32'd0;
    #12;
    check("reset_result", dif.div_result, 64'd0);
    check("reset_ready", {63'd0, dif.div_ready}, 64'd0);
    check("reset_stall", {58'd0, stall}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Stall priority with no divide in flight.
    stallreq_id = 1'b1;
    @(negedge clk);
    check("stall_id_only", {58'd0, stall}, {58'd0, 6'b000111});
    stallreq_id = 1'b0;
    @(negedge clk);
    check("stall_none", {58'd0, stall}, 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'd12345, 32'd0, 1'b1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b1);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_div(32'd3, 32'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_div($urandom, $urandom_range(1, 32'hFFFF), i[0], 1'b0);
    end

    // Annul after 10 iterations: no result, stall released the same cycle.
    prev_result = dif.div_result;
    @(posedge clk); #1;
    dif.div_start  = 1'b1;
    dif.div_signed = 1'b0;
    dif.div_op1    = 32'd1000;
    dif.div_op2    = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    dif.div_annul = 1'b1;
    @(negedge clk);
    check("annul_stall", {58'd0, stall}, 64'd0);
    @(posedge clk); #1;
    dif.div_annul = 1'b0;
    dif.div_start = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_ready) ready_seen++;
    end
    check("annul_ready_seen", 64'(ready_seen), 64'd0);
    check("annul_result_hold", dif.div_result, prev_result);

    // Asynchronous reset mid-divide clears everything at once.
    @(posedge clk); #1;
    dif.div_start = 1'b1;
    stallreq_id   = 1'b1;
    dif.div_op1   = 32'd999;
    dif.div_op2   = 32'd4;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_ex_over_id", {58'd0, stall}, {58'd0, 6'b001111});
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_stall", {58'd0, stall}, 64'd0);
    check("arst_ready", {63'd0, dif.div_ready}, 64'd0);
    check("arst_result", dif.div_result, 64'd0);
    dif.div_start = 1'b0;
    stallreq_id   = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_div(32'd81, 32'd9, 1'b0, 1'b0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle divide sequencer and pipeline stall controller for the EX stage. It accepts a 32-bit signed or unsigned divide request from EX and runs a radix-2 restoring divide, one quotient bit per cycle. While the divide is in flight it drives the 6-bit pipeline stall vector so that the ID/EX register and the stages before it hold. The vector also forwards ID-stage stall requests.

## Interface
Parameters:
- none; datapath width fixed at 32, iteration count fixed at 32.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- stallreq_id  input  1  ID stage requests a stall (e.g. load-use).
- div_start  input  1  EX holds a divide op; level, held by the stall until `div_ready`.
- div_signed  input  1  1 = signed divide, 0 = unsigned; sampled with start.
- div_annul  input  1  cancel the in-flight divide (flush).
- div_op1  input  32  dividend; sampled when leaving IDLE.
- div_op2  input  32  divisor; sampled when leaving IDLE.
- div_result  output  32+32  {remainder[63:32], quotient[31:0]}, registered.
- div_ready  output  1  result valid; high only in END.
- stall  output  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE, `div_start`=1, `div_annul`=0:
  - If `div_op2`==0, go to DIVZERO.
  - Otherwise latch operands and go to ON with cnt=0. In signed mode the operands are latched as absolute values and their sign bits are recorded.
- DIVZERO: result = 0 (quotient 0, remainder 0); go to END.
- ON, cnt<32: one restoring step.
  - Form a 33-bit difference: partial remainder minus divisor.
  - If the difference is non-negative, the partial remainder becomes the difference and the quotient bit is 1.
  - Otherwise the partial remainder is kept and the quotient bit is 0.
  - Shift left, MSB first. Increment cnt.
- ON, cnt==32: apply the sign fix-up, register `div_result`, go to END.
  - Signed mode, operand signs differ: negate the quotient (two's complement).
  - Signed mode, dividend negative: negate the remainder.
  - Unsigned mode: no fix-up.
- END:
  - `div_ready`=1 and `div_result` is held.
  - On `div_start`=0, go to IDLE and drop `div_ready`. `div_result` keeps its value until the next completion.
- `div_annul`=1 in DIVZERO or ON: go to IDLE next edge; no result written; `div_ready` stays 0.
- `div_annul` in IDLE suppresses the start. In END, annul is ignored.
- `div_start` falling during DIVZERO or ON without annul: the operation still completes to END, then returns to IDLE at the next edge.
- Width rules:
  - Signed quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0; no trap.
  - Divide by zero is not flagged; the result is 0.
- Stall generation (combinational):
  - stallreq_ex = `div_start` & ~`div_ready` & ~`div_annul`.
  - If stallreq_ex: `stall`=6'b001111.
  - Else if `stallreq_id`: `stall`=6'b000111.
  - Otherwise `stall`=0. EX has priority over ID.

## Timing
- Reset (asynchronous, immediate): state=IDLE, cnt=0, `div_result`=0, `div_ready`=0.
- `stall` is 0 while `reset_n`=0.
- Normal divide latency: start sampled at edge E0 (IDLE→ON), iterations at E1..E32, result at E33 (ON→END). `div_ready` is high in the cycle after E33, i.e. 34 cycles after start is first seen.
- Divide by zero: E0 IDLE→DIVZERO, E1 →END; `div_ready` high after 2 edges.
- `stall` bit2 is high from the cycle start first rises through the last cycle before `div_ready`. It drops in the same cycle `div_ready` rises, so the ID/EX register advances on the next edge.
- Back-to-back divides: END→IDLE requires one cycle with `div_start`=0. A start on the following cycle begins a new divide.
- Reset asserted mid-operation aborts immediately; there is no partial result.

## Test plan
- Unsigned 100/7: `div_start`=1 with op1=100, op2=7, signed=0 → after 34 cycles `div_ready`=1, result {2, 14}; `stall`=6'b001111 for the 34 preceding cycles.
- Signed -7/2: op1=0xFFFFFFF9, op2=2, signed=1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, signed=1 → quotient 0x80000000, remainder 0.
- Divide by zero: op2=0 → `div_ready` after 2 edges, result 0.
- Annul at iteration 10: raise `div_annul` → IDLE next edge; `div_ready` never rises; `div_result` keeps its prior value; `stall` is 0 the same cycle.
- Stall priority: `stallreq_id`=1 with no divide → `stall`=6'b000111. `stallreq_id`=1 during a divide → 6'b001111. Asynchronous reset mid-divide → all outputs 0 at once.
